// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - ID/EX operand bundle and writeback/stall signals of the EX multiply/divide unit
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic [6:0]      ex_t;
  logic [2:0]      ex_st;
  logic            ex_md;
  logic [XLEN-1:0] ex_n1;
  logic [XLEN-1:0] ex_n2;
  logic [4:0]      ex_wa;
  logic            ex_we;
  logic            flush;
  logic [XLEN-1:0] md_wdata;
  logic [4:0]      md_wa;
  logic            md_we;
  logic            md_busy;
  logic            stl_md;

  modport master (
    output ex_t, ex_st, ex_md, ex_n1, ex_n2, ex_wa, ex_we, flush,
    input  md_wdata, md_wa, md_we, md_busy, stl_md
  );

  modport slave (
    input  ex_t, ex_st, ex_md, ex_n1, ex_n2, ex_wa, ex_we, flush,
    output md_wdata, md_wa, md_we, md_busy, stl_md
  );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit with stall and one-cycle writeback
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave io
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      f3;
  logic [4:0]      wa_q;
  logic            we_q;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] opb;
  // mul: {partial hi, multiplier lo}; div: {remainder, dividend/quotient}
  logic [2*XLEN-1:0] acc;

  logic            req;
  logic            s1, s2, na, nb;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf, spec_div;
  logic [XLEN:0]   mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_nx, div_nx, prod;
  logic [XLEN-1:0] quo, rem, res;

  assign req = (io.ex_t == 7'h33) && io.ex_md && (state == IDLE) && !io.flush;

  always_comb begin
    s1   = (io.ex_st == 3'd1) || (io.ex_st == 3'd2) || (io.ex_st == 3'd4) || (io.ex_st == 3'd6);
    s2   = (io.ex_st == 3'd1) || (io.ex_st == 3'd4) || (io.ex_st == 3'd6);
    na   = s1 && io.ex_n1[XLEN-1];
    nb   = s2 && io.ex_n2[XLEN-1];
    mag1 = na ? -io.ex_n1 : io.ex_n1;
    mag2 = nb ? -io.ex_n2 : io.ex_n2;
    div_zero = (io.ex_n2 == '0);
    div_ovf  = !io.ex_st[0] && (io.ex_n1 == MIN_INT) && (io.ex_n2 == '1);
    spec_div = io.ex_st[2] && (div_zero || div_ovf);
  end

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_nx    = {mul_sum, acc[XLEN-1:1]};
    div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opb};
    div_nx    = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // Magnitudes are iterated; signs are applied once when the result is taken.
  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (!f3[2]) res = (f3 == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else        res = f3[1] ? rem : quo;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) begin
        if (!io.ex_st[2]) state_nx = MUL;
        else if (spec_div) state_nx = DONE;
        else state_nx = DIV;
      end
      MUL:  if (cnt == '1) state_nx = DONE;
      DIV:  if (cnt == '1) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (io.flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      f3          <= '0;
      wa_q        <= '0;
      we_q        <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      opb         <= '0;
      acc         <= '0;
      io.md_wdata <= '0;
      io.md_wa    <= '0;
      io.md_we    <= 1'b0;
    end else begin
      io.md_we <= 1'b0;
      if (io.flush) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: if (req) begin
            f3    <= io.ex_st;
            wa_q  <= io.ex_wa;
            we_q  <= io.ex_we;
            cnt   <= '0;
            opb   <= mag2;
            neg_q <= na ^ nb;
            neg_r <= na;
            acc   <= {{XLEN{1'b0}}, mag1};
            if (spec_div) begin
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              if (div_zero) acc <= {io.ex_n1, {XLEN{1'b1}}};
              else          acc <= {{XLEN{1'b0}}, MIN_INT};
            end
          end
          MUL: begin
            acc <= mul_nx;
            cnt <= cnt + 1'b1;
          end
          DIV: begin
            acc <= div_nx;
            cnt <= cnt + 1'b1;
          end
          DONE: begin
            io.md_we    <= we_q;
            io.md_wa    <= wa_q;
            io.md_wdata <= res;
          end
          default: ;
        endcase
      end
    end
  end

  assign io.md_busy = (state == MUL) || (state == DIV);
  assign io.stl_md  = rst && (req || io.md_busy);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv with random ops against an arithmetic model
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32)) bus ();

  ex_muldiv #(.XLEN(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    case (f3)
      3'd0: begin p = sa * sb; pu = p; return pu[31:0]; end
      3'd1: begin p = sa * sb; pu = p; return pu[63:32]; end
      3'd2: begin p = sa * ub; pu = p; return pu[63:32]; end
      3'd3: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; pu = p; return pu[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; pu = p; return pu[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic bubble();
    bus.ex_t  = 7'h00;
    bus.ex_md = 1'b0;
    bus.ex_st = 3'd0;
    bus.ex_n1 = '0;
    bus.ex_n2 = '0;
    bus.ex_wa = '0;
    bus.ex_we = 1'b0;
  endtask

  // Presents one instruction on ID/EX and holds it while the unit stalls.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic we, input logic [31:0] exp,
                       output int stl_cnt);
    bit done;
    bus.ex_t  = 7'h33;
    bus.ex_md = 1'b1;
    bus.ex_st = f3;
    bus.ex_n1 = a;
    bus.ex_n2 = b;
    bus.ex_wa = wa;
    bus.ex_we = we;
    if (we) exp_q.push_back({wa, exp});
    stl_cnt = 0;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.stl_md) stl_cnt++;
      else begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL stall_timeout: stl_md still high after 100 cycles");
    end
    @(posedge clk);
    #1;
    bubble();
  endtask

  initial begin : monitor
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (bus.md_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_md_we: wa %0d data %h, expected no writeback", bus.md_wa, bus.md_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("md_wdata", bus.md_wdata, e[31:0]);
          chk("md_wa", {27'h0, bus.md_wa}, {27'h0, e[36:32]});
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : stim
    int sc;
    logic [2:0] f3;
    logic [31:0] a, b;
    logic [4:0] wa;
    logic we;
    bus.flush = 1'b0;
    bus.ex_t  = 7'h33;
    bus.ex_md = 1'b1;
    bus.ex_st = 3'd0;
    bus.ex_n1 = 32'd3;
    bus.ex_n2 = 32'd5;
    bus.ex_wa = 5'd1;
    bus.ex_we = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stl_md", {31'h0, bus.stl_md}, 32'h0);
    chk("reset_md_we", {31'h0, bus.md_we}, 32'h0);
    chk("reset_md_busy", {31'h0, bus.md_busy}, 32'h0);
    chk("reset_md_wdata", bus.md_wdata, 32'h0);
    bubble();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // MUL 7 * -3 with latency checks
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 32'hFFFF_FFEB, sc);
    chk("mul_stl_cycles", sc, 32'd33);
    @(negedge clk);
    chk("mul_md_we_cycle34", {31'h0, bus.md_we}, 32'h1);
    @(negedge clk);
    chk("mul_md_we_one_cycle", {31'h0, bus.md_we}, 32'h0);
    chk("mul_wdata_hold", bus.md_wdata, 32'hFFFF_FFEB);
    @(posedge clk); #1;

    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b1, 32'h4000_0000, sc);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1, 32'hFFFF_FFFE, sc);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1, 32'hFFFF_FFFF, sc);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1, 32'hFFFF_FFFD, sc);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1, 32'hFFFF_FFFF, sc);
    issue(3'd5, 32'd100, 32'd7, 5'd11, 1'b1, 32'd14, sc);
    chk("divu_stl_cycles", sc, 32'd33);
    issue(3'd7, 32'd100, 32'd7, 5'd0, 1'b1, 32'd2, sc);

    // special-case divides: one stall cycle, writeback in the following cycle
    issue(3'd5, 32'd5, 32'd0, 5'd12, 1'b1, 32'hFFFF_FFFF, sc);
    chk("divz_stl_cycles", sc, 32'd1);
    @(negedge clk);
    chk("divz_md_we_next", {31'h0, bus.md_we}, 32'h1);
    @(posedge clk); #1;
    issue(3'd7, 32'd5, 32'd0, 5'd13, 1'b1, 32'd5, sc);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 32'h8000_0000, sc);
    chk("ovf_stl_cycles", sc, 32'd1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'h0, sc);

    // flush at iteration 10
    @(posedge clk); #1;
    bus.ex_t = 7'h33; bus.ex_md = 1'b1; bus.ex_st = 3'd0;
    bus.ex_n1 = 32'd1234; bus.ex_n2 = 32'd77; bus.ex_wa = 5'd20; bus.ex_we = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    bubble();
    @(negedge clk);
    chk("flush_stl_drop", {31'h0, bus.stl_md}, 32'h0);
    chk("flush_busy_drop", {31'h0, bus.md_busy}, 32'h0);
    repeat (40) @(posedge clk);
    #1;

    // flush with a request in IDLE suppresses it
    bus.ex_t = 7'h33; bus.ex_md = 1'b1; bus.ex_st = 3'd1; bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_no_stall", {31'h0, bus.stl_md}, 32'h0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    bubble();
    @(negedge clk);
    chk("flush_idle_no_busy", {31'h0, bus.md_busy}, 32'h0);
    @(posedge clk); #1;

    // asynchronous reset at iteration 20
    bus.ex_t = 7'h33; bus.ex_md = 1'b1; bus.ex_st = 3'd3;
    bus.ex_n1 = 32'hDEAD_BEEF; bus.ex_n2 = 32'h1234_5678; bus.ex_wa = 5'd21; bus.ex_we = 1'b1;
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("areset_md_wdata", bus.md_wdata, 32'h0);
    chk("areset_md_we", {31'h0, bus.md_we}, 32'h0);
    chk("areset_md_busy", {31'h0, bus.md_busy}, 32'h0);
    chk("areset_stl_md", {31'h0, bus.stl_md}, 32'h0);
    bubble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    issue(3'd0, 32'd12345, 32'd678, 5'd22, 1'b1, 32'd8369910, sc);

    // back-to-back MUL then DIV held by a stalled ID/EX
    issue(3'd0, 32'd9, 32'd11, 5'd23, 1'b1, 32'd99, sc);
    issue(3'd4, 32'd1000, 32'hFFFF_FFF6, 5'd24, 1'b1, 32'hFFFF_FF9C, sc);

    // randomized traffic with bubbles and non-M instructions
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      wa = 5'($urandom_range(0, 31));
      we = ($urandom_range(0, 7) != 0);
      issue(f3, a, b, wa, we, ref_md(f3, a, b), sc);
      if ($urandom_range(0, 2) == 0) begin
        bus.ex_t = ($urandom_range(0, 1) == 0) ? 7'h33 : 7'h13;
        bus.ex_md = (bus.ex_t == 7'h33) ? 1'b0 : 1'b1;
        bus.ex_n1 = $urandom;
        @(negedge clk);
        chk("non_m_no_stall", {31'h0, bus.stl_md}, 32'h0);
        @(posedge clk);
        #1 bubble();
      end
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, downstream of the ID/EX pipeline register.
- Consumes the registered ex_* bundle and executes OP-opcode instructions with funct7 = 0000001.
- Asserts a stall so ID/EX and earlier stages hold while it works.
- Delivers a one-cycle writeback result that EX muxes ahead of its ALU result.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = XLEN.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low (rst == 0 resets).
- ex_t  in  7  opcode from ID/EX; 7'h33 = OP.
- ex_st  in  3  funct3 from ID/EX.
- ex_md  in  1  funct7 == 0000001 (M-extension select).
- ex_n1  in  XLEN  rs1 value.
- ex_n2  in  XLEN  rs2 value.
- ex_wa  in  5  destination register.
- ex_we  in  1  destination write enable.
- flush  in  1  synchronous kill (branch mispredict / trap).
- md_wdata  out  XLEN  result.
- md_wa  out  5  result destination.
- md_we  out  1  result valid/write strobe; high exactly one cycle.
- md_busy  out  1  high in MUL or DIV state.
- stl_md  out  1  stall request to ID/EX and IF; combinational.

Behaviour:
- Request: req = (ex_t == 7'h33) && ex_md && state == IDLE && !flush.
- States: IDLE, MUL, DIV, DONE. Encoding is free.
- Reset (rst low, asynchronous):
  - state = IDLE, counter = 0.
  - md_wdata = 0, md_wa = 0, md_we = 0, md_busy = 0.
  - stl_md = 0 while held in reset.
- IDLE:
  - On req, latch funct3, ex_wa and ex_we.
  - Latch operand magnitudes and sign flags per funct3:
    - 0 MUL: either; low word.
    - 1 MULH: s×s.
    - 2 MULHSU: s×u.
    - 3 MULHU: u×u.
    - 4 DIV: signed.
    - 5 DIVU: unsigned.
    - 6 REM: signed.
    - 7 REMU: unsigned.
  - funct3 0–3 → MUL. funct3 4–7 → DIV, except special cases, which go directly to DONE with the result computed that cycle:
    - Divide by zero: quotient = 0xFFFFFFFF, remainder = ex_n1.
    - Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- MUL: shift-add on magnitudes into a 2×XLEN accumulator, one bit per cycle.
  - After XLEN cycles (counter wraps 31→0), negate the 64-bit product if the operand signs differ.
  - Select the low word (MUL) or high word (others) → DONE.
- DIV: restoring division on magnitudes, one quotient bit per cycle, XLEN cycles.
  - Quotient sign = sign(n1) XOR sign(n2).
  - Remainder sign = sign(n1).
  - Select quotient (DIV/DIVU) or remainder (REM/REMU) → DONE.
- DONE:
  - md_we = latched ex_we, md_wa = latched wa, md_wdata = result; all registered.
  - Always → IDLE next cycle.
  - md_wdata holds its value afterwards; md_we returns to 0.
- stl_md = req || state == MUL || state == DIV. It is low in DONE so ID/EX advances on the edge ending DONE, and IDLE then sees the next instruction; no double issue.
- Latency:
  - Normal ops: request cycle + 32 iterate cycles + DONE. md_we is high 34 cycles after the request cycle begins, and stl_md is high for 33 cycles.
  - Special-case divides: stl_md high 1 cycle; md_we in the next cycle.
- Non-M instructions, or ex_t == 0 (bubble): block stays IDLE; md_we = 0, stl_md = 0.
- flush:
  - In any state, → IDLE next edge.
  - No md_we is issued for the killed operation; counter is cleared.
  - flush in IDLE with a valid request suppresses the request.
  - flush has priority over DONE (md_we forced 0).
- Reset mid-operation: immediate abort, outputs to reset values, no writeback.
- ex_wa == 0 is passed through; the register file ignores x0 writes.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3) → md_wdata = 0xFFFFFFEB, md_we one cycle.
  - Check stl_md high exactly 33 cycles and md_we 34 cycles after the request.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM of the same operands → 0.
  - Each special case: stl_md high 1 cycle, md_we in the following cycle.
- Back-to-back MUL then DIV held by a stalled ID/EX.
  - Two distinct md_we pulses with correct wa; no duplicate issue of the first op.
- flush at iteration 10 → IDLE next cycle, no md_we, stl_md drops.
  - Drive rst low at iteration 20 → all outputs 0 immediately (asynchronous).
  - After rst release, a new MUL completes normally.
